bus_controller: RTL and testbench
=================================

# bus_controller

Parametrised single-master memory/peripheral bus controller sitting between the CPU load/store unit and the on-chip slaves (ROM, RAM, I/O). Decodes the top address nibble into up to `NUM_REGIONS` regions, runs a valid/ready request and response handshake, and inserts per-region wait states. It also generates byte-lane write strobes for byte, half and word stores, and aligns and sign- or zero-extends loads. Unmapped or misaligned accesses terminate with an error response and never reach a slave.

## Interface
Parameters:
- `NUM_REGIONS`, 4: number of decoded regions; region index = `addr[31:28]`, mapped iff index < `NUM_REGIONS` (1..16).
- `WAIT_W`, 4: width of each wait-state count.
- `WAIT_STATES`, all zero: packed `NUM_REGIONS*WAIT_W` vector; field i = extra access cycles for region i.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE and low while `rst`=1.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1=store, 0=load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal (error).
- `req_signed` in 1: loads only; 1=sign-extend.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: master accepts response.
- `resp_rdata` out 32: aligned, extended load data; 0 for stores and errors.
- `resp_err` out 1: unmapped, misaligned or illegal size.
- `slv_sel` out `NUM_REGIONS`: one-hot region select.
- `slv_addr` out 24: `addr[23:0]` of the latched request.
- `slv_we` out 1: write pulse.
- `slv_wstrb` out 4: byte-lane enables.
- `slv_wdata` out 32: store data replicated into lanes.
- `slv_rdata` in `NUM_REGIONS*32`: combinational read word per region; region i = bits [32i+31:32i].

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/we/size/signed/wdata.
  - Unmapped region, size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0: go to RESP with `resp_err`=1. No `slv_sel` and no `slv_we`.
  - Otherwise load counter = `WAIT_STATES[r]` and go to ACCESS.
- ACCESS: `slv_sel[r]`=1 for counter+1 cycles; counter decrements.
  - On the cycle counter==0: `slv_we`=`req_we` and `slv_wstrb` is valid (single write per transaction). The selected `slv_rdata` word is registered at the end of this cycle. Go to RESP.
- RESP: `resp_valid`=1 and outputs held stable until `resp_valid & resp_ready`, then go to IDLE.
- Strobes: byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << {addr[1],1'b0}`; word → `4'b1111`. `slv_wdata`: byte value replicated ×4, half value replicated ×2, word unchanged.
- Load align: word shifted right by 8·`addr[1:0]`, masked to size, then sign- or zero-extended to 32 bits.
- `slv_sel`, `slv_we`, `slv_wstrb` are 0 outside ACCESS. `slv_wstrb` is also 0 for loads.

## Timing
- Reset (while `rst`=1 and the cycle after): state IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `slv_sel`=0, `slv_we`=0, `slv_wstrb`=0, `slv_addr`=0, `slv_wdata`=0, counter=0. `req_ready`=1 from the first cycle after `rst` deasserts.
- Accept in cycle 0 → ACCESS in cycles 1..W+1 → `resp_valid` in cycle W+2 at the earliest (W=0 gives 2 cycles).
- Error: `resp_valid` in cycle 1.
- Throughput: at most one transaction in flight. The next request is accepted in the cycle after the response handshake.
- `resp_ready` low: RESP holds indefinitely with no slave activity.
- `rst` mid-ACCESS or mid-RESP: transaction aborted and no response issued. A write whose final ACCESS cycle coincides with `rst` is suppressed (`slv_we`=0).
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `bus_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, `REGION_MSB`=31, `REGION_LSB`=28, `SLV_ADDR_W`=24.
- Sub-module `lane_align` (combinational): store strobe/replicate and load shift/extend, shared with future DMA master.

## Test plan
- Word store 0xDEADBEEF to 0x1000_0008, region 1 with W=0 → `slv_sel`=0010 and `slv_we` for exactly 1 cycle, `slv_wstrb`=1111, `slv_addr`=0x000008, `resp_valid` in cycle 2, `resp_err`=0.
- Byte store 0xA5 to 0x1000_0003 → `slv_wstrb`=1000, `slv_wdata`=0xA5A5A5A5. Signed byte load at the same address with `slv_rdata`=0xA5000000 → `resp_rdata`=0xFFFFFFA5; unsigned load → 0x000000A5.
- Region 2 with `WAIT_STATES` field=3, half load at 0x2000_0002, `slv_rdata`=0x80010000 signed → `slv_sel` high 4 cycles, `resp_valid` in cycle 5, `resp_rdata`=0xFFFF8001.
- Load from 0x5000_0000 with `NUM_REGIONS`=4; word load at 0x1000_0002; size 11 → each gives `resp_err`=1 in cycle 1, `resp_rdata`=0, `slv_sel` never asserted.
- `resp_ready` held low 10 cycles → `resp_valid` and `resp_rdata` stable, `req_ready`=0. Then `rst` pulsed during a W=3 store → no `slv_we`, all outputs at reset values, `req_ready`=1 after reset.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings and address-field positions for the bus controller.
package bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;
  localparam int SLV_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/bus_controller_lane_align.sv
// Byte-lane steering: store strobes/replication and load shift/extension.
module lane_align (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  import bus_pkg::*;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sgn);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {{24{sgn & v[7]}}, v[7:0]};
      SZ_HALF: r = {{16{sgn & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [31:0] shifted;

  // Store side: lane enables and data replicated so any lane sees the value.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = rword >> {addr_lo, 3'b000};
    rdata_ext = extend(shifted, size, is_signed);
  end

endmodule

// File: rtl/bus_controller.sv
// Single-master bus controller: region decode, wait states, handshakes.
module bus_controller #(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 4,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] WAIT_STATES = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [NUM_REGIONS-1:0]    slv_sel,
  output logic [23:0]               slv_addr,
  output logic                      slv_we,
  output logic [3:0]                slv_wstrb,
  output logic [31:0]               slv_wdata,
  input  logic [NUM_REGIONS*32-1:0] slv_rdata
);
  import bus_pkg::*;

  state_t                state_q, state_d;
  logic [SLV_ADDR_W-1:0] addr_p0;
  logic [3:0]            region_p0;
  logic                  we_p0;
  logic                  sgn_p0;
  logic [1:0]            size_p0;
  logic [31:0]           wdata_p0;
  logic [WAIT_W-1:0]     cnt_p0;
  logic                  err_p1;
  logic [31:0]           rdata_p1;

  logic [3:0]  req_region;
  logic        req_bad;
  logic [31:0] rword;
  logic [3:0]  strb;
  logic [31:0] wrep;
  logic [31:0] rext;
  logic        unused_addr;

  assign req_region  = req_addr[REGION_MSB:REGION_LSB];
  assign unused_addr = ^req_addr[REGION_LSB-1:SLV_ADDR_W];

  function automatic logic [WAIT_W-1:0] wait_of(input logic [3:0] r);
    logic [WAIT_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (r == 4'(i)) w = WAIT_STATES[i*WAIT_W +: WAIT_W];
    return w;
  endfunction

  // Requests that must never reach a slave: unmapped, illegal size, misaligned.
  always_comb begin
    req_bad = ({28'd0, req_region} >= 32'(NUM_REGIONS));
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) req_bad = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
      default: req_bad = 1'b1;
    endcase
  end

  // Read-word mux for the latched region.
  always_comb begin
    rword = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (region_p0 == 4'(i)) rword = slv_rdata[i*32 +: 32];
  end

  lane_align u_lane_align (
    .addr_lo   (addr_p0[1:0]),
    .size      (size_p0),
    .is_signed (sgn_p0),
    .wdata     (wdata_p0),
    .rword     (rword),
    .wstrb     (strb),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and outputs; everything is forced quiet while rst is high.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    slv_sel    = '0;
    slv_we     = 1'b0;
    slv_wstrb  = 4'b0000;
    slv_addr   = addr_p0;
    slv_wdata  = wrep;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        for (int i = 0; i < NUM_REGIONS; i++)
          slv_sel[i] = (region_p0 == 4'(i));
        if (cnt_p0 == '0) begin
          slv_we    = we_p0;
          slv_wstrb = we_p0 ? strb : 4'b0000;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_p1;
        resp_rdata = rdata_p1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      slv_sel    = '0;
      slv_we     = 1'b0;
      slv_wstrb  = 4'b0000;
      slv_addr   = '0;
      slv_wdata  = '0;
    end
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p0   <= '0;
      region_p0 <= '0;
      we_p0     <= 1'b0;
      sgn_p0    <= 1'b0;
      size_p0   <= SZ_BYTE;
      wdata_p0  <= '0;
      cnt_p0    <= '0;
      err_p1    <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_p0   <= req_addr[SLV_ADDR_W-1:0];
            region_p0 <= req_region;
            we_p0     <= req_we;
            sgn_p0    <= req_signed;
            size_p0   <= req_size;
            wdata_p0  <= req_wdata;
            err_p1    <= req_bad;
            rdata_p1  <= '0;
            cnt_p0    <= req_bad ? '0 : wait_of(req_region);
          end
        end
        ST_ACCESS: begin
          if (cnt_p0 != '0) cnt_p0 <= cnt_p0 - WAIT_W'(1);
          else              rdata_p1 <= we_p0 ? '0 : rext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed table, corner sequences, random.
module tb_bus_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [3:0]   slv_sel;
  logic [23:0]  slv_addr;
  logic         slv_we;
  logic [3:0]   slv_wstrb;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;

  // region wait states: r0=2, r1=0, r2=3, r3=1
  bus_controller #(
    .NUM_REGIONS (4),
    .WAIT_W      (4),
    .WAIT_STATES (16'h1302)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .slv_sel    (slv_sel),
    .slv_addr   (slv_addr),
    .slv_we     (slv_we),
    .slv_wstrb  (slv_wstrb),
    .slv_wdata  (slv_wdata),
    .slv_rdata  (slv_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [7:0]  lat;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int waits(input int r);
    case (r)
      0: return 2;
      1: return 0;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  // Reference model: expected response from the access rules alone.
  function automatic vec_t fill_exp(input vec_t v);
    int r, n, a;
    logic [31:0] d, mask;
    r = int'(v.addr[31:28]);
    a = int'(v.addr[1:0]);
    v.err = 1'b0; v.rdata = '0; v.strb = '0; v.wrep = '0;
    n = 0;
    if (v.size == 2'd3) v.err = 1'b1;
    else begin
      n = 1 << v.size;
      if (r >= 4 || (a % n) != 0) v.err = 1'b1;
    end
    v.lat = v.err ? 8'd1 : 8'(waits(r) + 2);
    if (!v.err && v.we) begin
      v.strb = 4'(((1 << n) - 1) << a);
      for (int k = 0; k < 4; k++) v.wrep[8*k +: 8] = v.wdata[8*(k % n) +: 8];
    end
    if (!v.err && !v.we) begin
      d    = v.rword >> (8 * a);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      d    = d & mask;
      if (v.sgn && n < 4 && d[8*n-1]) d = d | ~mask;
      v.rdata = d;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int hold, input string tag);
    logic [3:0]  sel_or, strb_or, exp_sel;
    logic [31:0] wd, sa;
    logic        got_err;
    logic [31:0] got_rd;
    int selcnt, wecnt, n;
    sel_or = '0; strb_or = '0; wd = '0; sa = '0; selcnt = 0; wecnt = 0;
    for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = $urandom;
    if (v.addr[31:28] < 4'd4) slv_rdata[int'(v.addr[31:28])*32 +: 32] = v.rword;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_we = v.we; req_size = v.size;
    req_signed = v.sgn; req_wdata = v.wdata;
    @(posedge clk); #1;
    // junk request held valid while busy must be ignored
    req_addr = $urandom; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_wdata = $urandom;
    for (n = 1; n <= 40; n++) begin
      sel_or  |= slv_sel;
      strb_or |= slv_wstrb;
      if (slv_sel != 4'd0) begin selcnt++; sa = 32'(slv_addr); end
      if (slv_we) begin wecnt++; wd = slv_wdata; end
      if (resp_valid) break;
      @(posedge clk); #1;
    end
    got_err = resp_err;
    got_rd  = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, v.rdata);
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      sel_or |= slv_sel;
      wecnt  += int'(slv_we);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_sel = v.err ? 4'd0 : 4'(1 << v.addr[31:28]);
    chk({tag, "_latency"}, 32'(n), 32'(v.lat));
    chk({tag, "_err"}, 32'(got_err), 32'(v.err));
    chk({tag, "_rdata"}, got_rd, v.rdata);
    chk({tag, "_sel"}, 32'(sel_or), 32'(exp_sel));
    chk({tag, "_sel_cycles"}, 32'(selcnt), v.err ? 32'd0 : 32'(v.lat - 8'd1));
    chk({tag, "_we_pulses"}, 32'(wecnt), 32'(v.we && !v.err));
    chk({tag, "_wstrb"}, 32'(strb_or), 32'(v.strb));
    if (v.we && !v.err) chk({tag, "_wdata"}, wd, v.wrep);
    if (!v.err) chk({tag, "_slv_addr"}, sa, {8'd0, v.addr[23:0]});
  endtask

  vec_t tbl[12];
  vec_t rv;
  int   act;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0; slv_rdata = '0;

    tbl[0]  = '{32'h1000_0008, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,
                1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 8'd2};
    tbl[1]  = '{32'h1000_0003, 1'b1, 2'd0, 1'b0, 32'h1234_56A5, 32'h0,
                1'b0, 32'h0, 4'h8, 32'hA5A5_A5A5, 8'd2};
    tbl[2]  = '{32'h1000_0003, 1'b0, 2'd0, 1'b1, 32'h0, 32'hA500_0000,
                1'b0, 32'hFFFF_FFA5, 4'h0, 32'h0, 8'd2};
    tbl[3]  = '{32'h1000_0003, 1'b0, 2'd0, 1'b0, 32'h0, 32'hA500_0000,
                1'b0, 32'h0000_00A5, 4'h0, 32'h0, 8'd2};
    tbl[4]  = '{32'h2000_0002, 1'b0, 2'd1, 1'b1, 32'h0, 32'h8001_0000,
                1'b0, 32'hFFFF_8001, 4'h0, 32'h0, 8'd5};
    tbl[5]  = '{32'h5000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1111_1111,
                1'b1, 32'h0, 4'h0, 32'h0, 8'd1};
    tbl[6]  = '{32'h1000_0002, 1'b0, 2'd2, 1'b0, 32'h0, 32'h2222_2222,
                1'b1, 32'h0, 4'h0, 32'h0, 8'd1};
    tbl[7]  = '{32'h1000_0000, 1'b0, 2'd3, 1'b0, 32'h0, 32'h3333_3333,
                1'b1, 32'h0, 4'h0, 32'h0, 8'd1};
    tbl[8]  = '{32'h0000_0002, 1'b1, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0,
                1'b0, 32'h0, 4'hC, 32'hBEEF_BEEF, 8'd4};
    tbl[9]  = '{32'h3000_0000, 1'b0, 2'd1, 1'b0, 32'h0, 32'h1234_F00D,
                1'b0, 32'h0000_F00D, 4'h0, 32'h0, 8'd3};
    tbl[10] = '{32'hF000_0000, 1'b1, 2'd0, 1'b0, 32'h0000_00FF, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 8'd1};
    tbl[11] = '{32'h0000_0001, 1'b0, 2'd1, 1'b1, 32'h0, 32'hFFFF_FFFF,
                1'b1, 32'h0, 4'h0, 32'h0, 8'd1};

    // reset values, while rst is high and just after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_outputs", {resp_rdata | slv_wdata}, 32'd0);
    chk("rst_slv_ctl", {19'd0, resp_err, slv_sel, slv_we, slv_wstrb}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("idle_slv_addr", 32'(slv_addr), 32'd0);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);

    // directed table
    for (int i = 0; i < 12; i++) run_txn(tbl[i], 0, $sformatf("tbl%0d", i));

    // response held with resp_ready low for 10 cycles
    rv = '{32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D,
           1'b0, 32'hCAFE_F00D, 4'h0, 32'h0, 8'd4};
    run_txn(rv, 10, "hold");

    // reset during the last ACCESS cycle of a W=3 word store
    slv_rdata = {4{32'h5555_AAAA}};
    req_valid = 1'b1; req_addr = 32'h2000_0010; req_we = 1'b1; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("abort_sel", 32'(slv_sel), 32'h4);
      chk("abort_early_we", 32'(slv_we), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_final_we", 32'(slv_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_suppressed", 32'(slv_we), 32'd0);
    chk("abort_strb_suppressed", 32'(slv_wstrb), 32'd0);
    @(posedge clk); #1;
    chk("abort_rst_outputs", {resp_rdata | slv_wdata}, 32'd0);
    chk("abort_rst_ctl", {18'd0, req_ready, resp_valid, slv_sel, slv_we, slv_wstrb, 4'd0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_slv_addr", 32'(slv_addr), 32'd0);
    act = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid || slv_we || slv_sel != 4'd0) act++;
      @(posedge clk); #1;
    end
    chk("abort_no_response", 32'(act), 32'd0);

    // randomized transactions against the reference model
    for (int i = 0; i < 150; i++) begin
      rv = '0;
      rv.addr  = {4'($urandom_range(0, 5)), 28'($urandom)};
      rv.we    = 1'($urandom);
      rv.size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.sgn   = 1'($urandom);
      rv.wdata = $urandom;
      rv.rword = $urandom;
      rv = fill_exp(rv);
      run_txn(rv, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
